// File: rtl/serial_pkg.sv
// Shared definitions for the serial scheduler.
// Holds the scheduler FSM state encoding, the record size in bytes, and the
// nibble that marks a tagged record.
// No ports (package).

package serial_pkg;

  localparam int         REC_BYTES  = 6;
  localparam logic [3:0] TAG_NIBBLE = 4'hA;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_LOAD,
    S_FIRE,
    S_WAIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first asserted request at or after ptr, wrapping modulo NREQ.
// Ports:
//   req       in   NREQ  request levels
//   ptr       in   4     highest-priority index for this pick
//   grant     out  NREQ  one-hot grant (all zero when no request)
//   grant_id  out  4     binary index of the granted requester (0 when none)

module rr_arbiter import serial_pkg::*; #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [3:0]      ptr,
  output logic [NREQ-1:0] grant,
  output logic [3:0]      grant_id
);

  logic found;

  // Walk the priority order starting at ptr; the first hit wins.
  // The inner loop keeps every bit select constant after unrolling.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && req[j] && (j == (int'(ptr) + i) % NREQ)) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          grant_id = 4'(j);
        end
      end
    end
  end

endmodule

// File: rtl/serial_sched.sv
// Round-robin scheduler sharing one serial transmitter between NREQ requesters.
// The winning requester's record is latched into a hold register, fed to the
// transmitter LSB byte first (one byte per ser_get cycle), then ser_send fires,
// the transmitter's shift time is waited out and the winner receives an ack pulse.
// Optional feature: define SERIAL_SCHED_TAG_EN to overwrite the top record byte
// with {4'hA, grant_id} so the receiver can identify the source.
// Ports:
//   clk        in   1              system clock
//   rst        in   1              synchronous reset, active-high
//   req        in   NREQ           request levels, held until ack
//   payload    in   NREQ*NBYTES*8  records; requester i at [48*i +: 48]
//   ack        out  NREQ           one-cycle completion pulse to the winner
//   grant_id   out  4              current/last granted requester
//   busy       out  1              high from ARB through DONE
//   ser_data   out  8              byte presented to the transmitter
//   ser_get    out  1              transmitter byte-load strobe
//   ser_send   out  1              transmitter start strobe

module serial_sched import serial_pkg::*; #(
  parameter int NREQ      = 4,
  parameter int NBYTES    = REC_BYTES,
  parameter int TX_CYCLES = 49
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*NBYTES*8-1:0] payload,
  output logic [NREQ-1:0]        ack,
  output logic [3:0]             grant_id,
  output logic                   busy,
  output logic [7:0]             ser_data,
  output logic                   ser_get,
  output logic                   ser_send
);

  localparam int REC_BITS = NBYTES * 8;
  localparam int WW       = $clog2(TX_CYCLES);

  state_t              state_q, state_d;
  logic [3:0]          rr_ptr_q, rr_ptr_d;
  logic [3:0]          byte_cnt_q, byte_cnt_d;
  logic [WW-1:0]       wait_cnt_q, wait_cnt_d;
  logic [REC_BITS-1:0] hold_q, hold_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic [3:0]          grant_id_q, grant_id_d;
  logic                busy_q, busy_d;
  logic [7:0]          ser_data_q, ser_data_d;
  logic                ser_get_q, ser_get_d;
  logic                ser_send_q, ser_send_d;

  logic [NREQ-1:0]     arb_grant;
  logic [3:0]          arb_id;
  logic [REC_BITS-1:0] arb_rec;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req      (req),
    .ptr      (rr_ptr_q),
    .grant    (arb_grant),
    .grant_id (arb_id)
  );

  // Record of the current arbitration winner, tagged when the feature is built in.
  always_comb begin
    arb_rec = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (arb_grant[j]) arb_rec = payload[j*REC_BITS +: REC_BITS];
    end
`ifdef SERIAL_SCHED_TAG_EN
    arb_rec[REC_BITS-1 -: 8] = {TAG_NIBBLE, arb_id};
`endif
  end

  // Next-state and next-output logic. Outputs are registered, so each strobe
  // is set on the transition into the state where it must be visible.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    byte_cnt_d = byte_cnt_q;
    wait_cnt_d = wait_cnt_q;
    hold_d     = hold_q;
    ack_d      = '0;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    ser_data_d = ser_data_q;
    ser_get_d  = 1'b0;
    ser_send_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_ARB;
          busy_d  = 1'b1;
        end
      end
      S_ARB: begin
        // A request withdrawn before arbitration leaves nothing to send.
        if (|arb_grant) begin
          state_d    = S_LOAD;
          hold_d     = arb_rec;
          grant_id_d = arb_id;
          byte_cnt_d = '0;
          ser_data_d = arb_rec[7:0];
          ser_get_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_LOAD: begin
        if (int'(byte_cnt_q) == NBYTES - 1) begin
          state_d    = S_FIRE;
          ser_send_d = 1'b1;
        end else begin
          byte_cnt_d = byte_cnt_q + 4'd1;
          ser_data_d = 8'(hold_q >> (8 * (int'(byte_cnt_q) + 1)));
          ser_get_d  = 1'b1;
        end
      end
      S_FIRE: begin
        state_d    = S_WAIT;
        wait_cnt_d = '0;
      end
      S_WAIT: begin
        if (int'(wait_cnt_q) == TX_CYCLES - 1) begin
          state_d = S_DONE;
          for (int j = 0; j < NREQ; j++) ack_d[j] = (grant_id_q == 4'(j));
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        busy_d   = 1'b0;
        rr_ptr_d = (int'(grant_id_q) == NREQ - 1) ? 4'd0 : grant_id_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      byte_cnt_q <= '0;
      wait_cnt_q <= '0;
      hold_q     <= '0;
      ack_q      <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      ser_data_q <= '0;
      ser_get_q  <= 1'b0;
      ser_send_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      hold_q     <= hold_d;
      ack_q      <= ack_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      ser_data_q <= ser_data_d;
      ser_get_q  <= ser_get_d;
      ser_send_q <= ser_send_d;
    end
  end

  assign ack      = ack_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign ser_data = ser_data_q;
  assign ser_get  = ser_get_q;
  assign ser_send = ser_send_q;

endmodule

// File: tb/tb_serial_sched.sv
// Testbench for serial_sched (default parameters: 4 requesters, 6-byte records,
// 49-cycle transmitter busy time). A reference model predicts the winner of each
// arbitration and the bytes it must send; a monitor checks what the DUT presents.

module tb_serial_sched;

  localparam int NREQ      = 4;
  localparam int NBYTES    = 6;
  localparam int TX_CYCLES = 49;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NREQ-1:0]  req = '0;
  logic [47:0]      pl [NREQ];
  logic [NREQ*48-1:0] payload;
  logic [NREQ-1:0]  ack;
  logic [3:0]       grant_id;
  logic             busy;
  logic [7:0]       ser_data;
  logic             ser_get;
  logic             ser_send;

  assign payload = {pl[3], pl[2], pl[1], pl[0]};

  serial_sched #(.NREQ(NREQ), .NBYTES(NBYTES), .TX_CYCLES(TX_CYCLES)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .payload  (payload),
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy),
    .ser_data (ser_data),
    .ser_get  (ser_get),
    .ser_send (ser_send)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard: bytes and ack winners the model expects, in order.
  logic [7:0] exp_bytes [$];
  int         exp_ack   [$];
  int         model_ptr = 0;

  int ack_events  = 0;
  int send_events = 0;
  int get_events  = 0;
  int cyc         = 0;
  int send_cyc    = 0;
  int get_run     = 0;
  bit prev_send   = 1'b0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Inputs change 1 time unit after the falling edge, after the monitor has sampled.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference model: the winner is the first requester at or after the rotation
  // pointer; its record goes out LSB byte first. Drives req as well.
  task automatic applyStimulus(input logic [NREQ-1:0] mask, input bit expect_ack, output int winner);
    logic [47:0] rec;
    winner = -1;
    for (int i = 0; i < NREQ; i++) begin
      int c;
      c = (model_ptr + i) % NREQ;
      if (winner < 0 && ((mask >> c) & 4'd1) != 4'd0) winner = c;
    end
    rec = pl[winner[1:0]];
`ifdef SERIAL_SCHED_TAG_EN
    rec[47:40] = {4'hA, 4'(winner)};
`endif
    for (int k = 0; k < NBYTES; k++) exp_bytes.push_back(8'(rec >> (8 * k)));
    if (expect_ack) begin
      exp_ack.push_back(winner);
      model_ptr = (winner + 1) % NREQ;
    end
    req = mask;
  endtask

  task automatic waitAck(input string name);
    int start;
    int n;
    start = ack_events;
    n = 0;
    while (ack_events == start && n < 400) begin
      tick();
      n++;
    end
    checkOutput({name, "_ack_seen"}, longint'(ack_events != start), 1);
  endtask

  task automatic waitGet(input string name);
    int start;
    int n;
    start = get_events;
    n = 0;
    while (get_events == start && n < 100) begin
      tick();
      n++;
    end
    checkOutput({name, "_get_seen"}, longint'(get_events != start), 1);
  endtask

  task automatic waitSend(input string name);
    int start;
    int n;
    start = send_events;
    n = 0;
    while (send_events == start && n < 100) begin
      tick();
      n++;
    end
    checkOutput({name, "_send_seen"}, longint'(send_events != start), 1);
  endtask

  // Monitor: compares every byte load, send and ack against the scoreboard.
  always @(negedge clk) begin : monitor
    int w;
    cyc++;
    if (rst) begin
      get_run   = 0;
      prev_send = 1'b0;
    end else begin
      if (ser_get || ser_send) begin
        checkOutput("get_send_exclusive", longint'(ser_get & ser_send), 0);
        checkOutput("busy_during_strobe", longint'(busy), 1);
      end
      if (ser_get) begin
        get_run++;
        get_events++;
        if (exp_bytes.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL get_unexpected: got ser_get with data %0h, expected none", ser_data);
        end else begin
          checkOutput("ser_data", longint'(ser_data), longint'(exp_bytes.pop_front()));
        end
      end
      if (ser_send) begin
        send_events++;
        checkOutput("gets_per_record", get_run, NBYTES);
        checkOutput("send_one_cycle", longint'(prev_send), 0);
        get_run  = 0;
        send_cyc = cyc;
      end
      prev_send = ser_send;
      if (ack != '0) begin
        ack_events++;
        if (exp_ack.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL ack_unexpected: got ack %0h, expected none", ack);
        end else begin
          w = exp_ack.pop_front();
          checkOutput("ack", longint'(ack), longint'(1) << w);
          checkOutput("grant_id", longint'(grant_id), w);
          // FIRE cycle, then TX_CYCLES of WAIT, then DONE carries the ack.
          checkOutput("send_to_ack", cyc - send_cyc, TX_CYCLES + 1);
        end
      end
    end
  end

  initial begin : stimulus
    int w;
    int n;
    int start;
    int mode;
    for (int i = 0; i < NREQ; i++) pl[i] = '0;

    // T1: reset held with every requester asking; nothing may move.
    rst = 1'b1;
    req = 4'hF;
    repeat (3) begin
      tick();
      checkOutput("t1_ack", longint'(ack), 0);
      checkOutput("t1_grant_id", longint'(grant_id), 0);
      checkOutput("t1_busy", longint'(busy), 0);
      checkOutput("t1_ser_data", longint'(ser_data), 0);
      checkOutput("t1_ser_get", longint'(ser_get), 0);
      checkOutput("t1_ser_send", longint'(ser_send), 0);
    end
    req = '0;
    rst = 1'b0;
    tick();

    // T3: all requesters held for 8 records -> strict rotation from 0.
    for (int i = 0; i < NREQ; i++) pl[i] = {16'($urandom), $urandom};
    for (int r = 0; r < 8; r++) begin
      applyStimulus(4'hF, 1'b1, w);
      waitAck("t3");
    end
    req = '0;
    repeat (3) tick();

    // T2: single requester; ack lands in the 59th cycle counting the cycle
    // in which req is first seen as cycle 1.
    pl[2] = 48'h665544332211;
    applyStimulus(4'b0100, 1'b1, w);
    start = ack_events;
    n = 0;
    while (ack_events == start && n < 400) begin
      tick();
      n++;
    end
    checkOutput("t2_latency", n + 1, 1 + 1 + NBYTES + 1 + TX_CYCLES + 1);
    req = '0;
    repeat (2) tick();

    // T6: requester 3 with an all-zero record; the top byte shows the tag if built in.
    pl[3] = 48'h0;
    applyStimulus(4'b1000, 1'b1, w);
    waitAck("t6");
    req = '0;
    repeat (2) tick();

    // T4: record changed during LOAD; the latched bytes must still go out.
    pl[1] = 48'hA1B2C3D4E5F6;
    applyStimulus(4'b0010, 1'b1, w);
    waitGet("t4");
    pl[1] = ~pl[1];
    waitAck("t4");
    req = '0;
    repeat (2) tick();

    // T5: rotation now points at 2. Reset in WAIT at wait_cnt=20 must kill
    // the ack and return rotation to 0, so requesters 1,2 then grant 1.
    applyStimulus(4'b0110, 1'b0, w);
    waitSend("t5");
    repeat (21) tick();
    rst = 1'b1;
    req = '0;
    start = ack_events;
    repeat (3) tick();
    rst = 1'b0;
    checkOutput("t5_busy_after_reset", longint'(busy), 0);
    checkOutput("t5_grant_id_after_reset", longint'(grant_id), 0);
    repeat (60) tick();
    checkOutput("t5_no_ack", ack_events, start);
    checkOutput("t5_bytes_drained", exp_bytes.size(), 0);
    model_ptr = 0;
    applyStimulus(4'b0110, 1'b1, w);
    waitAck("t5_restart");
    req = '0;
    repeat (2) tick();

    // Random rounds: random masks and records, sometimes dropping req or
    // changing the winner's record once loading has started.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NREQ; i++) pl[i] = {16'($urandom), $urandom};
      applyStimulus(4'($urandom_range(1, 15)), 1'b1, w);
      mode = int'($urandom_range(0, 2));
      if (mode != 0) begin
        waitGet("rand");
        if (mode == 1) req = '0;
        else pl[w[1:0]] = ~pl[w[1:0]];
      end
      waitAck("rand");
    end
    req = '0;
    repeat (5) tick();

    checkOutput("bytes_left", exp_bytes.size(), 0);
    checkOutput("acks_left", exp_ack.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
